// File: rtl/call_stack_if.sv
// ============================================================================
//  Module      : call_stack_if
//  Description : EX-stage control/PC inputs and redirect/status outputs of the
//                return-address stack, grouped as one bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface call_stack_if #(
    parameter int PTR_W = 4
);
    logic             call;
    logic             ret;
    logic             pop;
    logic [31:0]      PC;
    logic [25:0]      J_type_imm;
    logic             stall;
    logic             flush;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic [PTR_W:0]   count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;
    logic             multi_op;

    // Pipeline side: drives the latched EX controls, observes redirect/status.
    modport master (
        output call, ret, pop, PC, J_type_imm, stall, flush,
        input  redirect_valid, redirect_pc, count, empty, full,
        input  overflow, underflow, multi_op
    );

    // Stack side.
    modport slave (
        input  call, ret, pop, PC, J_type_imm, stall, flush,
        output redirect_valid, redirect_pc, count, empty, full,
        output overflow, underflow, multi_op
    );
endinterface

`default_nettype wire

// File: rtl/call_stack_unit.sv
// ============================================================================
//  Module      : call_stack_unit
//  Description : Execute-stage hardware return-address stack. A call pushes
//                PC+1 and redirects fetch to {PC[31:26], J_type_imm}; a ret
//                pops and redirects to the popped address; a pop discards the
//                top entry. Sticky overflow/underflow/multi-op flags.
//                Optional build macro CALL_STACK_WRAP_EN: circular storage,
//                a call while full overwrites the oldest entry and overflow
//                is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module call_stack_unit #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    call_stack_if.slave bus
);

    localparam logic [PTR_W:0] c_depth_cnt = (PTR_W+1)'(DEPTH);

    logic [31:0]      r_stack [DEPTH];
    logic [PTR_W-1:0] r_sp;
    logic [PTR_W:0]   r_count;
    logic             r_redirect_valid;
    logic [31:0]      r_redirect_pc;
    logic             r_overflow;
    logic             r_underflow;
    logic             r_multi_op;

    logic             w_accept;
    logic             w_do_call;
    logic             w_do_ret;
    logic             w_do_pop;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pull;
    logic             w_multi;
    logic [PTR_W-1:0] w_sp_inc;
    logic [PTR_W-1:0] w_sp_dec;
    logic [PTR_W:0]   w_count_inc;
    logic [1:0]       w_op_sum;

    // Operation decode: accept gating and call > ret > pop priority.
    always_comb begin
        w_accept    = !bus.stall && !bus.flush;
        w_do_call   = w_accept && bus.call;
        w_do_ret    = w_accept && bus.ret && !bus.call;
        w_do_pop    = w_accept && bus.pop && !bus.call && !bus.ret;
        w_empty     = (r_count == '0);
        w_full      = (r_count == c_depth_cnt);
        w_sp_inc    = r_sp + 1'b1;
        w_sp_dec    = r_sp - 1'b1;
        w_op_sum    = {1'b0, bus.call} + {1'b0, bus.ret} + {1'b0, bus.pop};
        w_multi     = w_accept && (w_op_sum > 2'd1);
        // A ret/pop on an empty stack changes nothing but the underflow flag.
        w_pull      = (w_do_ret || w_do_pop) && !w_empty;
`ifdef CALL_STACK_WRAP_EN
        // Circular storage: every call writes; count saturates at DEPTH.
        w_push      = w_do_call;
        w_count_inc = w_full ? r_count : r_count + 1'b1;
`else
        // A call on a full stack drops the push but still redirects.
        w_push      = w_do_call && !w_full;
        w_count_inc = r_count + 1'b1;
`endif
    end

    // Entry storage: written on push only, intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[r_sp] <= bus.PC + 32'd1;
        end
    end

    // Pointer, depth count, redirect and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp             <= '0;
            r_count          <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_overflow       <= 1'b0;
            r_underflow      <= 1'b0;
            r_multi_op       <= 1'b0;
        end else begin
            r_redirect_valid <= 1'b0;
            if (w_push) begin
                r_sp    <= w_sp_inc;
                r_count <= w_count_inc;
            end else if (w_pull) begin
                r_sp    <= w_sp_dec;
                r_count <= r_count - 1'b1;
            end
            if (w_do_call) begin
                r_redirect_valid <= 1'b1;
                r_redirect_pc    <= {bus.PC[31:26], bus.J_type_imm};
            end else if (w_do_ret && !w_empty) begin
                r_redirect_valid <= 1'b1;
                r_redirect_pc    <= r_stack[w_sp_dec];
            end
`ifndef CALL_STACK_WRAP_EN
            if (w_do_call && w_full) begin
                r_overflow <= 1'b1;
            end
`endif
            if ((w_do_ret || w_do_pop) && w_empty) begin
                r_underflow <= 1'b1;
            end
            if (w_multi) begin
                r_multi_op <= 1'b1;
            end
        end
    end

    assign bus.redirect_valid = r_redirect_valid;
    assign bus.redirect_pc    = r_redirect_pc;
    assign bus.count          = r_count;
    assign bus.empty          = w_empty;
    assign bus.full           = w_full;
    assign bus.overflow       = r_overflow;
    assign bus.underflow      = r_underflow;
    assign bus.multi_op       = r_multi_op;

endmodule

`default_nettype wire

// File: tb/tb_call_stack_unit.sv
// ============================================================================
//  Module      : tb_call_stack_unit
//  Description : Self-checking bench for call_stack_unit (DEPTH=4). Directed
//                scenarios followed by random traffic, all compared against a
//                queue-based model of a return-address stack.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_call_stack_unit;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic clk;
    logic rst_n;

    call_stack_if #(.PTR_W(PTR_W)) bus ();

    call_stack_unit #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_q [$];
    bit          m_ovf;
    bit          m_unf;
    bit          m_multi;
    bit          e_rv;
    logic [31:0] e_rpc;

    int passed;
    int total;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed=%h expected=%h at %0t", tag, obs, exp, $time);
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".rv"},    32'(bus.redirect_valid), 32'(e_rv));
        if (e_rv) chk({tag, ".rpc"}, bus.redirect_pc, e_rpc);
        chk({tag, ".count"}, 32'(bus.count),     32'(m_q.size()));
        chk({tag, ".empty"}, 32'(bus.empty),     32'(m_q.size() == 0));
        chk({tag, ".full"},  32'(bus.full),      32'(m_q.size() == DEPTH));
        chk({tag, ".ovf"},   32'(bus.overflow),  32'(m_ovf));
        chk({tag, ".unf"},   32'(bus.underflow), 32'(m_unf));
        chk({tag, ".multi"}, 32'(bus.multi_op),  32'(m_multi));
    endtask

    // One clock of EX traffic: update the model, clock the DUT, compare.
    task automatic step(input string tag, input bit c, input bit r, input bit p,
                        input logic [31:0] pc, input logic [25:0] imm,
                        input bit st, input bit fl);
        bus.call = c; bus.ret = r; bus.pop = p; bus.PC = pc;
        bus.J_type_imm = imm; bus.stall = st; bus.flush = fl;
        e_rv = 1'b0;
        if (!st && !fl) begin
            if ((int'(c) + int'(r) + int'(p)) > 1) m_multi = 1'b1;
            if (c) begin
                e_rv  = 1'b1;
                e_rpc = {pc[31:26], imm};
                if (m_q.size() < DEPTH) m_q.push_back(pc + 32'd1);
                else begin
`ifdef CALL_STACK_WRAP_EN
                    void'(m_q.pop_front());
                    m_q.push_back(pc + 32'd1);
`else
                    m_ovf = 1'b1;
`endif
                end
            end else if (r || p) begin
                if (m_q.size() == 0) m_unf = 1'b1;
                else begin
                    e_rpc = m_q.pop_back();
                    e_rv  = r;
                end
            end
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    // Asynchronous reset asserted between edges; checked before any edge.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        m_q.delete();
        m_ovf = 1'b0; m_unf = 1'b0; m_multi = 1'b0; e_rv = 1'b0;
        check_outputs(tag);
        chk({tag, ".rpc0"}, bus.redirect_pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        passed = 0; total = 0;
        m_ovf = 0; m_unf = 0; m_multi = 0; e_rv = 0; e_rpc = '0;
        bus.call = 0; bus.ret = 0; bus.pop = 0; bus.PC = '0;
        bus.J_type_imm = '0; bus.stall = 0; bus.flush = 0;
        rst_n = 1'b1;
        @(posedge clk);
        async_reset("reset");

        // Basic call / ret
        step("call100", 1, 0, 0, 32'h100, 26'h200, 0, 0);
        chk("call100.tgt", bus.redirect_pc, 32'h200);
        step("ret205", 0, 1, 0, 32'h205, 26'h0, 0, 0);
        chk("ret205.tgt", bus.redirect_pc, 32'h101);
        step("idle", 0, 0, 0, 32'h0, 26'h0, 0, 0);

        // Fill, overflow/wrap, drain
        for (int i = 1; i <= 5; i++) step("fill", 1, 0, 0, 32'(10 * i), 26'(i), 0, 0);
        step("ret_a", 0, 1, 0, 32'h0, 26'h0, 0, 0);
`ifdef CALL_STACK_WRAP_EN
        chk("wrap.first", bus.redirect_pc, 32'd51);
`else
        chk("nowrap.first", bus.redirect_pc, 32'd41);
`endif
        for (int i = 0; i < 3; i++) step("ret_b", 0, 1, 0, 32'h0, 26'h0, 0, 0);
`ifdef CALL_STACK_WRAP_EN
        chk("wrap.last", bus.redirect_pc, 32'd21);
`else
        chk("nowrap.last", bus.redirect_pc, 32'd11);
`endif

        // Underflow on empty
        step("ret_empty", 0, 1, 0, 32'h0, 26'h0, 0, 0);
        step("pop_empty", 0, 0, 1, 32'h0, 26'h0, 0, 0);

        // PC+1 wrap at top of address space
        step("call_top", 1, 0, 0, 32'hFFFF_FFFF, 26'h3FF_FFFF, 0, 0);
        step("ret_top", 0, 1, 0, 32'h0, 26'h0, 0, 0);

        // Stall and flush
        for (int i = 0; i < 3; i++) step("stall", 1, 0, 0, 32'h300, 26'h40, 1, 0);
        step("unstall", 1, 0, 0, 32'h300, 26'h40, 0, 0);
        step("after", 0, 0, 0, 32'h0, 26'h0, 0, 0);
        step("flush", 1, 0, 0, 32'h400, 26'h50, 0, 1);

        // Simultaneous call+ret with two entries
        step("c2", 1, 0, 0, 32'h500, 26'h60, 0, 0);
        step("multi", 1, 1, 0, 32'h600, 26'h70, 0, 0);
        step("pop_ret", 0, 1, 1, 32'h0, 26'h0, 0, 0);

        // Reset mid-sequence
        async_reset("midreset");
        step("post_rst_ret", 0, 1, 0, 32'h0, 26'h0, 0, 0);

        // Random traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            int unsigned k;
            logic [31:0] pc;
            k  = $urandom_range(0, 99);
            pc = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFF : $urandom;
            if (k < 2) async_reset("rnd_rst");
            else step("rnd",
                      $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 35,
                      $urandom_range(0, 99) < 15, pc, 26'($urandom),
                      $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
